// File: rtl/lwc_pre_processor.sv
// LWC API front end for SpoC-64: strips PDI/SDI instruction and segment headers
// and forwards payload words onto the controller's bdi and key handshakes.
module lwc_pre_processor (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pdi_data,
  input  logic        pdi_valid,
  output logic        pdi_ready,
  input  logic [31:0] sdi_data,
  input  logic        sdi_valid,
  output logic        sdi_ready,
  output logic [31:0] key,
  output logic        key_valid,
  input  logic        key_ready,
  output logic        key_update,
  output logic [31:0] bdi,
  output logic        bdi_valid,
  input  logic        bdi_ready,
  output logic [3:0]  bdi_type,
  output logic        bdi_eot,
  output logic        bdi_eoi,
  output logic [2:0]  bdi_size,
  output logic [3:0]  bdi_valid_bytes,
  output logic        decrypt
);

  localparam logic [3:0] OP_ACTKEY = 4'b0111;
  localparam logic [3:0] OP_ENC    = 4'b0010;
  localparam logic [3:0] OP_DEC    = 4'b0011;
  localparam logic [3:0] T_NPUB    = 4'b1101;
  localparam logic [3:0] T_TAG     = 4'b1000;

  typedef enum logic [3:0] {
    IDLE, SDI_HDR, SDI_KEY, NPUB_HDR, NPUB, DATA_HDR, DATA, TAG_HDR, TAG
  } state_t;

  state_t      r_state;
  logic        r_key_update;
  logic        r_decrypt;
  logic        r_eoi;
  logic [1:0]  r_cnt;
  logic [15:0] r_len;
  logic [3:0]  r_type;

  logic        w_last;
  logic        w_bdi_en;
  logic [2:0]  w_size;
  logic        w_pdi_hs;
  logic        w_sdi_hs;
  state_t      w_after_eoi;

  function automatic logic [3:0] size_to_mask(input logic [2:0] size);
    case (size)
      3'd4:    return 4'b1111;
      3'd3:    return 4'b1110;
      3'd2:    return 4'b1100;
      3'd1:    return 4'b1000;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic [31:0] mask_to_bits(input logic [3:0] m);
    return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
  endfunction

  function automatic logic [15:0] sat_dec4(input logic [15:0] len);
    return (len > 16'd4) ? (len - 16'd4) : 16'd0;
  endfunction

  assign w_last      = (r_len <= 16'd4);
  assign w_after_eoi = r_decrypt ? TAG_HDR : IDLE;
  assign w_pdi_hs    = pdi_valid & pdi_ready;
  assign w_sdi_hs    = sdi_valid & sdi_ready;
  assign key         = sdi_data;
  assign key_update  = r_key_update;
  assign decrypt     = r_decrypt;

  always_comb begin
    pdi_ready = 1'b0;
    sdi_ready = 1'b0;
    key_valid = 1'b0;
    bdi_valid = 1'b0;
    bdi_type  = 4'b0000;
    bdi_eot   = 1'b0;
    bdi_eoi   = 1'b0;
    w_size    = 3'd4;
    w_bdi_en  = 1'b0;
    // reset gates every handshake so nothing half-completes on the rst cycle
    if (!rst) begin
      case (r_state)
        IDLE, NPUB_HDR, DATA_HDR, TAG_HDR: pdi_ready = 1'b1;
        SDI_HDR: sdi_ready = 1'b1;
        SDI_KEY: begin
          key_valid = sdi_valid;
          sdi_ready = key_ready;
        end
        NPUB: begin
          w_bdi_en  = 1'b1;
          bdi_type  = T_NPUB;
          bdi_eot   = (r_cnt == 2'd3);
          bdi_eoi   = (r_cnt == 2'd3) & r_eoi;
        end
        DATA: begin
          w_bdi_en  = 1'b1;
          bdi_type  = r_type;
          bdi_eot   = w_last;
          bdi_eoi   = w_last & r_eoi;
          w_size    = w_last ? r_len[2:0] : 3'd4;
        end
        TAG: begin
          w_bdi_en  = 1'b1;
          bdi_type  = T_TAG;
          bdi_eot   = (r_cnt == 2'd1);
          bdi_eoi   = (r_cnt == 2'd1);
        end
        default: ;
      endcase
      if (w_bdi_en) begin
        bdi_valid = pdi_valid;
        pdi_ready = bdi_ready;
      end
    end
  end

  assign bdi_size        = w_size;
  assign bdi_valid_bytes = size_to_mask(w_size);
  assign bdi             = w_bdi_en ? (pdi_data & mask_to_bits(size_to_mask(w_size))) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_key_update <= 1'b0;
      r_decrypt    <= 1'b0;
      r_eoi        <= 1'b0;
      r_cnt        <= 2'd0;
      r_len        <= 16'd0;
    end else begin
      case (r_state)
        IDLE: if (w_pdi_hs) begin
          r_cnt <= 2'd0;
          if (pdi_data[31:28] == OP_ACTKEY) begin
            r_key_update <= 1'b1;
            r_state      <= SDI_HDR;
          end else if (pdi_data[31:28] == OP_ENC || pdi_data[31:28] == OP_DEC) begin
            r_decrypt <= (pdi_data[31:28] == OP_DEC);
            r_state   <= NPUB_HDR;
          end
        end
        // LDKEY instruction followed by the key segment header
        SDI_HDR: if (w_sdi_hs) begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd1) begin
            r_cnt   <= 2'd0;
            r_state <= SDI_KEY;
          end
        end
        SDI_KEY: if (w_sdi_hs) begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) begin
            r_key_update <= 1'b0;
            r_state      <= IDLE;
          end
        end
        NPUB_HDR: if (w_pdi_hs) begin
          r_eoi   <= pdi_data[26];
          r_cnt   <= 2'd0;
          r_state <= NPUB;
        end
        NPUB: if (w_pdi_hs) begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd3) r_state <= r_eoi ? w_after_eoi : DATA_HDR;
        end
        DATA_HDR: if (w_pdi_hs) begin
          r_type <= pdi_data[31:28];
          r_eoi  <= pdi_data[26];
          r_len  <= pdi_data[15:0];
          if (pdi_data[15:0] == 16'd0) begin
            if (pdi_data[26]) r_state <= w_after_eoi;
          end else begin
            r_state <= DATA;
          end
        end
        DATA: if (w_pdi_hs) begin
          r_len <= sat_dec4(r_len);
          if (w_last) r_state <= r_eoi ? w_after_eoi : DATA_HDR;
        end
        TAG_HDR: if (w_pdi_hs) begin
          r_cnt   <= 2'd0;
          r_state <= TAG;
        end
        TAG: if (w_pdi_hs) begin
          r_cnt <= r_cnt + 2'd1;
          if (r_cnt == 2'd1) begin
            r_cnt   <= 2'd0;
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lwc_pre_processor.sv
// Directed bench for lwc_pre_processor: key load, ENC/DEC flows, back-pressure,
// zero-length and partial segments, and reset mid-segment.
module tb_lwc_pre_processor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pdi_data;
  logic        pdi_valid;
  logic        pdi_ready;
  logic [31:0] sdi_data;
  logic        sdi_valid;
  logic        sdi_ready;
  logic [31:0] key;
  logic        key_valid;
  logic        key_ready;
  logic        key_update;
  logic [31:0] bdi;
  logic        bdi_valid;
  logic        bdi_ready;
  logic [3:0]  bdi_type;
  logic        bdi_eot;
  logic        bdi_eoi;
  logic [2:0]  bdi_size;
  logic [3:0]  bdi_valid_bytes;
  logic        decrypt;

  int n_tests = 0;
  int n_fail  = 0;

  lwc_pre_processor dut (
    .clk(clk), .rst(rst),
    .pdi_data(pdi_data), .pdi_valid(pdi_valid), .pdi_ready(pdi_ready),
    .sdi_data(sdi_data), .sdi_valid(sdi_valid), .sdi_ready(sdi_ready),
    .key(key), .key_valid(key_valid), .key_ready(key_ready), .key_update(key_update),
    .bdi(bdi), .bdi_valid(bdi_valid), .bdi_ready(bdi_ready), .bdi_type(bdi_type),
    .bdi_eot(bdi_eot), .bdi_eoi(bdi_eoi), .bdi_size(bdi_size),
    .bdi_valid_bytes(bdi_valid_bytes), .decrypt(decrypt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] flags();
    return 32'({bdi_valid, bdi_type, bdi_eot, bdi_eoi, bdi_size, bdi_valid_bytes});
  endfunction

  function automatic logic [31:0] exp_flags(input logic v, input logic [3:0] t, input logic eot,
                                            input logic eoi, input logic [2:0] sz, input logic [3:0] m);
    return 32'({v, t, eot, eoi, sz, m});
  endfunction

  // Each task starts 1 time unit after a rising edge and ends at the same phase.
  task automatic hdr(input string tag, input logic [31:0] d);
    pdi_data = d; pdi_valid = 1'b1; #1;
    chk({tag, "_rdy"}, 32'(pdi_ready), 32'd1);
    chk({tag, "_nobdi"}, 32'(bdi_valid), 32'd0);
    @(posedge clk); #1; pdi_valid = 1'b0;
  endtask

  task automatic sdi_word(input string tag, input logic [31:0] d);
    sdi_data = d; sdi_valid = 1'b1; #1;
    chk({tag, "_rdy"}, 32'(sdi_ready), 32'd1);
    @(posedge clk); #1; sdi_valid = 1'b0;
  endtask

  task automatic key_word(input string tag, input logic [31:0] d, input logic last);
    sdi_data = d; sdi_valid = 1'b1; key_ready = 1'b1; #1;
    chk({tag, "_kv"}, 32'({key_valid, sdi_ready, key_update}), 32'b111);
    chk({tag, "_key"}, key, d);
    @(posedge clk); #1; sdi_valid = 1'b0;
    chk({tag, "_upd"}, 32'(key_update), 32'(!last));
  endtask

  task automatic bdi_word(input string tag, input logic [31:0] d, input logic [31:0] eb,
                          input logic [3:0] t, input logic [2:0] sz, input logic [3:0] m,
                          input logic eot, input logic eoi);
    pdi_data = d; pdi_valid = 1'b1; bdi_ready = 1'b1; #1;
    chk({tag, "_flags"}, flags(), exp_flags(1'b1, t, eot, eoi, sz, m));
    chk({tag, "_data"}, bdi, eb);
    chk({tag, "_rdy"}, 32'(pdi_ready), 32'd1);
    @(posedge clk); #1; pdi_valid = 1'b0;
  endtask

  task automatic npub4(input string tag, input logic eoi);
    bdi_word({tag, "_n0"}, 32'h0001_0203, 32'h0001_0203, 4'hD, 3'd4, 4'hF, 1'b0, 1'b0);
    bdi_word({tag, "_n1"}, 32'h0405_0607, 32'h0405_0607, 4'hD, 3'd4, 4'hF, 1'b0, 1'b0);
    bdi_word({tag, "_n2"}, 32'h0809_0A0B, 32'h0809_0A0B, 4'hD, 3'd4, 4'hF, 1'b0, 1'b0);
    bdi_word({tag, "_n3"}, 32'h0C0D_0E0F, 32'h0C0D_0E0F, 4'hD, 3'd4, 4'hF, 1'b1, eoi);
  endtask

  task automatic idle_chk(input string tag, input logic dec);
    #1;
    chk({tag, "_idle"}, 32'({pdi_ready, bdi_valid, decrypt}), 32'({1'b1, 1'b0, dec}));
  endtask

  initial begin
    rst = 1'b1; pdi_data = '0; pdi_valid = 1'b0; sdi_data = '0; sdi_valid = 1'b0;
    key_ready = 1'b0; bdi_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rdy", 32'({pdi_ready, sdi_ready, key_valid}), 32'd0);
    rst = 1'b0; #1;
    chk("rst_flags", flags(), exp_flags(1'b0, 4'h0, 1'b0, 1'b0, 3'd4, 4'hF));
    chk("rst_ctl", 32'({pdi_ready, key_update, decrypt}), 32'b100);
    @(posedge clk); #1;

    // key load
    hdr("actkey", 32'h7000_0000);
    chk("actkey_upd", 32'({key_update, pdi_ready}), 32'b10);
    sdi_word("ldkey", 32'h4000_0000);
    sdi_word("keyhdr", 32'hC000_0010);
    key_word("k0", 32'h1111_1111, 1'b0);
    sdi_data = 32'h2222_2222; sdi_valid = 1'b1; key_ready = 1'b0; #1;
    chk("kstall", 32'({key_valid, sdi_ready, pdi_ready}), 32'b100);
    @(posedge clk); #1;
    key_word("k1", 32'h2222_2222, 1'b0);
    key_word("k2", 32'h3333_3333, 1'b0);
    key_word("k3", 32'h4444_4444, 1'b1);
    idle_chk("key_done", 1'b0);

    // ENC, AD len 5, PT len 8 EOI
    hdr("enc", 32'h2000_0000);
    hdr("npubh", 32'hD000_0010);
    npub4("enc", 1'b0);
    hdr("adh", 32'h1200_0005);
    bdi_word("ad0", 32'hA1A2_A3A4, 32'hA1A2_A3A4, 4'h1, 3'd4, 4'hF, 1'b0, 1'b0);
    bdi_word("ad1", 32'hB1B2_B3B4, 32'hB100_0000, 4'h1, 3'd1, 4'h8, 1'b1, 1'b0);
    hdr("pth", 32'h4600_0008);
    bdi_word("pt0", 32'hC1C2_C3C4, 32'hC1C2_C3C4, 4'h4, 3'd4, 4'hF, 1'b0, 1'b0);
    bdi_word("pt1", 32'hD1D2_D3D4, 32'hD1D2_D3D4, 4'h4, 3'd4, 4'hF, 1'b1, 1'b1);
    idle_chk("enc_done", 1'b0);

    // DEC, NPUB EOI, tag
    hdr("dec", 32'h3000_0000);
    chk("dec_flag", 32'(decrypt), 32'd1);
    hdr("npubh_d", 32'hD400_0010);
    npub4("dec", 1'b1);
    hdr("tagh", 32'h8600_0008);
    bdi_word("tag0", 32'hE1E2_E3E4, 32'hE1E2_E3E4, 4'h8, 3'd4, 4'hF, 1'b0, 1'b0);
    bdi_word("tag1", 32'hF1F2_F3F4, 32'hF1F2_F3F4, 4'h8, 3'd4, 4'hF, 1'b1, 1'b1);
    idle_chk("dec_done", 1'b1);

    // back-pressure mid-PT
    hdr("enc2", 32'h2000_0000);
    hdr("npubh2", 32'hD000_0010);
    npub4("bp", 1'b0);
    hdr("pth2", 32'h4600_0010);
    bdi_word("bp0", 32'h1010_1010, 32'h1010_1010, 4'h4, 3'd4, 4'hF, 1'b0, 1'b0);
    pdi_data = 32'h2020_2020; pdi_valid = 1'b1; bdi_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("stall_rdy", 32'(pdi_ready), 32'd0);
      chk("stall_flags", flags(), exp_flags(1'b1, 4'h4, 1'b0, 1'b0, 3'd4, 4'hF));
      chk("stall_data", bdi, 32'h2020_2020);
      @(posedge clk); #1;
    end
    bdi_word("bp1", 32'h2020_2020, 32'h2020_2020, 4'h4, 3'd4, 4'hF, 1'b0, 1'b0);
    bdi_word("bp2", 32'h3030_3030, 32'h3030_3030, 4'h4, 3'd4, 4'hF, 1'b0, 1'b0);
    bdi_word("bp3", 32'h4040_4040, 32'h4040_4040, 4'h4, 3'd4, 4'hF, 1'b1, 1'b1);
    idle_chk("bp_done", 1'b0);

    // zero-length AD then PT len 3
    hdr("enc3", 32'h2000_0000);
    hdr("npubh3", 32'hD000_0010);
    npub4("z", 1'b0);
    hdr("ad0h", 32'h1000_0000);
    hdr("pt3h", 32'h4600_0003);
    bdi_word("pt3", 32'h1122_3344, 32'h1122_3300, 4'h4, 3'd3, 4'hE, 1'b1, 1'b1);
    idle_chk("z_done", 1'b0);

    // reset mid-PT
    hdr("enc4", 32'h2000_0000);
    hdr("npubh4", 32'hD000_0010);
    npub4("r", 1'b0);
    hdr("pth4", 32'h4600_0010);
    bdi_word("r0", 32'h5050_5050, 32'h5050_5050, 4'h4, 3'd4, 4'hF, 1'b0, 1'b0);
    pdi_data = 32'h6060_6060; pdi_valid = 1'b1; rst = 1'b1; #1;
    chk("rst_mid", 32'({bdi_valid, pdi_ready}), 32'b00);
    @(posedge clk); #1;
    rst = 1'b0; pdi_valid = 1'b0; #1;
    chk("post_rst", flags(), exp_flags(1'b0, 4'h0, 1'b0, 1'b0, 3'd4, 4'hF));
    chk("post_rst_rdy", 32'(pdi_ready), 32'd1);
    @(posedge clk); #1;
    hdr("actkey2", 32'h7000_0000);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("rst_keyupd", 32'(key_update), 32'd0);
    hdr("enc5", 32'h2000_0000);
    hdr("npubh5", 32'hD400_0010);
    npub4("f", 1'b1);
    idle_chk("fresh_done", 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
